// File: rtl/ycr_mem_responder.sv
// ycr_mem_responder: local word memory that answers ycr core requests (byte/halfword/word, word bursts)
//   Optional feature macro YCR_MEMRESP_WS_EN: one wait cycle before every beat response (2 cycles per beat).
//   Ports:
//     clk, rst_n               clock, asynchronous active-low reset
//     core_req / core_req_ack  request handshake; ack high only while idle
//     core_cmd                 0 read, 1 write
//     core_width               0 byte, 1 halfword, 2 word, 3 illegal
//     core_addr                byte address, word index addr[log2(MEM_DEPTH)+1:2]
//     core_bl                  burst length in beats (0 means 1)
//     core_wdata               write data of the current beat
//     core_rdata / core_resp   registered beat response (NOTRDY, RDY_OK, RDY_ER, RDY_LOK)
`ifndef YCR_IMEM_AWIDTH
`define YCR_IMEM_AWIDTH 32
`endif
`ifndef YCR_IMEM_BSIZE
`define YCR_IMEM_BSIZE 3
`endif
`ifndef YCR_IMEM_DWIDTH
`define YCR_IMEM_DWIDTH 32
`endif
module ycr_mem_responder #(
  parameter int MEM_DEPTH = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        core_req,
  output logic                        core_req_ack,
  input  logic                        core_cmd,
  input  logic [1:0]                  core_width,
  input  logic [`YCR_IMEM_AWIDTH-1:0] core_addr,
  input  logic [`YCR_IMEM_BSIZE-1:0]  core_bl,
  input  logic [`YCR_IMEM_DWIDTH-1:0] core_wdata,
  output logic [`YCR_IMEM_DWIDTH-1:0] core_rdata,
  output logic [1:0]                  core_resp
);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam int AW = `YCR_IMEM_AWIDTH;
  localparam int BW = `YCR_IMEM_BSIZE;
  localparam int DW = `YCR_IMEM_DWIDTH;
  localparam logic [1:0] NOTRDY = 2'd0, RDY_OK = 2'd1, RDY_ER = 2'd2, RDY_LOK = 2'd3;
  typedef enum logic [1:0] {IDLE, READ, WRITE, ERR} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, cur_idx;
  logic [BW-1:0] cnt_q, cnt_d, n_q, n_d, n_in, cur_cnt;
  logic [3:0] be_q, be_d, be_in, cur_be;
  logic [1:0] resp_q, resp_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic acc, bad, busy, beat, last, cur_wr;
  logic [DW-1:0] mem [MEM_DEPTH];
`ifdef YCR_MEMRESP_WS_EN
  logic ph_q, ph_d;
`endif
  // The accept edge carries beat 0 straight from the request fields; later beats use the captured copies.
  always_comb begin
    acc = state_q == IDLE && core_req;
    busy = state_q == READ || state_q == WRITE;
    n_in = core_bl == '0 ? BW'(1) : core_bl;
    bad = |core_addr[AW-1:IW+2] || core_width == 2'd3 || (core_width == 2'd1 && core_addr[0]) ||
          (core_width == 2'd2 && core_addr[1:0] != 2'd0) || (n_in != BW'(1) && core_width != 2'd2);
    be_in = core_width == 2'd0 ? 4'b0001 << core_addr[1:0] : core_width == 2'd1 ? (core_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    cur_idx = acc ? core_addr[IW+1:2] : idx_q;
    cur_cnt = acc ? '0 : cnt_q;
    n_d = acc ? n_in : n_q;
    cur_be = acc ? be_in : be_q;
    cur_wr = acc ? core_cmd : state_q == WRITE;
    last = cur_cnt == n_d - BW'(1);
`ifdef YCR_MEMRESP_WS_EN
    // ph_q high marks the edge that ends a wait cycle and carries a beat.
    beat = busy && ph_q;
    ph_d = busy ? !ph_q : 1'b1;
`else
    beat = (acc && !bad) || busy;
`endif
    state_d = acc ? (bad ? ERR : (beat && last) ? IDLE : core_cmd ? WRITE : READ) :
              (state_q == ERR || (beat && last)) ? IDLE : state_q;
    resp_d = state_q == ERR ? RDY_ER : beat ? (last ? RDY_LOK : RDY_OK) : NOTRDY;
    rdata_d = beat && !cur_wr ? mem[cur_idx] : '0;
    idx_d = beat ? cur_idx + IW'(1) : cur_idx;
    cnt_d = beat ? cur_cnt + BW'(1) : cur_cnt;
    be_d = beat ? 4'b1111 : cur_be;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      n_q <= '0;
      be_q <= '0;
      resp_q <= NOTRDY;
      rdata_q <= '0;
`ifdef YCR_MEMRESP_WS_EN
      ph_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      n_q <= n_d;
      be_q <= be_d;
      resp_q <= resp_d;
      rdata_q <= rdata_d;
`ifdef YCR_MEMRESP_WS_EN
      ph_q <= ph_d;
`endif
    end
  end
  // Storage is deliberately outside the reset domain so completed writes survive a reset.
  always_ff @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (beat && cur_wr && cur_be[b]) mem[cur_idx][8*b +: 8] <= core_wdata[8*b +: 8];
  assign core_req_ack = state_q == IDLE;
  assign core_resp = resp_q;
  assign core_rdata = rdata_q;
endmodule

// File: tb/tb_ycr_mem_responder.sv
// tb_ycr_mem_responder: scoreboard bench for ycr_mem_responder (MEM_DEPTH 256)
`ifndef YCR_IMEM_AWIDTH
`define YCR_IMEM_AWIDTH 32
`endif
`ifndef YCR_IMEM_BSIZE
`define YCR_IMEM_BSIZE 3
`endif
`ifndef YCR_IMEM_DWIDTH
`define YCR_IMEM_DWIDTH 32
`endif
module tb_ycr_mem_responder;
  localparam logic [1:0] NR = 2'd0, OK = 2'd1, ER = 2'd2, LOK = 2'd3;
  logic clk = 1'b0, rst_n = 1'b1, core_req = 1'b0, core_cmd = 1'b0, core_req_ack;
  logic [1:0] core_width = 2'd0, core_resp;
  logic [`YCR_IMEM_AWIDTH-1:0] core_addr = '0;
  logic [`YCR_IMEM_BSIZE-1:0] core_bl = '0;
  logic [31:0] core_wdata = '0, core_rdata;
  logic [33:0] sb[$];
  logic [33:0] e;
  int n_vec = 0, n_err = 0;
  ycr_mem_responder #(.MEM_DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .core_req(core_req), .core_req_ack(core_req_ack), .core_cmd(core_cmd),
    .core_width(core_width), .core_addr(core_addr), .core_bl(core_bl), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_resp(core_resp));
  always #5 clk = ~clk;
  task automatic start(input logic cmd, input logic [1:0] w, input logic [31:0] a, input logic [2:0] bl, input logic [31:0] d);
    core_req = 1'b1;
    core_cmd = cmd;
    core_width = w;
    core_addr = a;
    core_bl = bl;
    core_wdata = d;
  endtask
  task automatic push_beat(input logic [1:0] r, input logic [31:0] d);
`ifdef YCR_MEMRESP_WS_EN
    sb.push_back(34'd0);
`endif
    sb.push_back({r, d});
  endtask
  task automatic push_err;
    sb.push_back(34'd0);
    sb.push_back({ER, 32'd0});
  endtask
  task automatic test_reset;
    #1 rst_n = 1'b0;
    #12;
    n_vec += 3;
    if (core_resp !== NR) begin n_err++; $display("FAIL rst_resp: got %h want %h", core_resp, NR); end
    if (core_rdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", core_rdata); end
    if (core_req_ack !== 1'b1) begin n_err++; $display("FAIL rst_ack: got %b want 1", core_req_ack); end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (core_req_ack !== 1'b1) begin n_err++; $display("FAIL rst_ack_rel: got %b want 1", core_req_ack); end
  endtask
  task automatic test_rw;
    logic [31:0] a[8] = '{32'h10, 32'h10, 32'h13, 32'h10, 32'h14, 32'h16, 32'h14, 32'h10};
    logic [1:0] w[8] = '{2, 2, 0, 2, 2, 1, 2, 2};
    logic cmd[8] = '{1, 0, 1, 0, 1, 1, 0, 0};
    logic [31:0] d[8] = '{32'hA5A5_1234, 0, 32'h7700_0000, 0, 32'h1122_3344, 32'hBEEF_DEAD, 0, 0};
    logic [31:0] x[8] = '{0, 32'hA5A5_1234, 0, 32'h77A5_1234, 0, 0, 32'hBEEF_3344, 32'h77A5_1234};
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (core_req_ack !== 1'b1) begin n_err++; $display("FAIL rw_ack[%0d]: got %b want 1", i, core_req_ack); end
      start(cmd[i], w[i], a[i], 3'(i == 7 ? 0 : 1), d[i]);
      push_beat(LOK, x[i]);
      while (sb.size() != 0) begin
        @(negedge clk);
        core_req = 1'b0;
        e = sb.pop_front();
        n_vec++;
        if ({core_resp, core_rdata} !== e) begin n_err++; $display("FAIL rw[%0d]: got %h/%h want %h/%h", i, core_resp, core_rdata, e[33:32], e[31:0]); end
      end
    end
  endtask
  task automatic test_burst;
    logic [31:0] wd[4] = '{1, 2, 3, 4};
    int k = 0;
    n_vec++;
    if (core_req_ack !== 1'b1) begin n_err++; $display("FAIL bw_ack: got %b want 1", core_req_ack); end
    start(1'b1, 2'd2, 32'h3F8, 3'd4, wd[0]);
    push_beat(OK, 0); push_beat(OK, 0); push_beat(OK, 0); push_beat(LOK, 0);
    while (sb.size() != 0) begin
      @(negedge clk);
      core_req = 1'b0;
      e = sb.pop_front();
      n_vec++;
      if ({core_resp, core_rdata} !== e) begin n_err++; $display("FAIL burst_wr: got %h/%h want %h/%h", core_resp, core_rdata, e[33:32], e[31:0]); end
      if (e[33:32] == OK && k < 3) begin k++; core_wdata = wd[k]; end
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (core_req_ack !== 1'b1) begin n_err++; $display("FAIL br_ack[%0d]: got %b want 1", i, core_req_ack); end
      case (i)
        0: begin start(1'b0, 2'd2, 32'h3F8, 3'd4, 0); push_beat(OK, 1); push_beat(OK, 2); push_beat(OK, 3); push_beat(LOK, 4); end
        1: begin start(1'b0, 2'd2, 32'h3F8, 3'd2, 0); push_beat(OK, 1); push_beat(LOK, 2); end
        2: begin start(1'b0, 2'd2, 32'h0, 3'd1, 0); push_beat(LOK, 3); end
        default: begin start(1'b0, 2'd2, 32'h3FC, 3'd1, 0); push_beat(LOK, 2); end
      endcase
      while (sb.size() != 0) begin
        @(negedge clk);
        core_req = 1'b0;
        e = sb.pop_front();
        n_vec++;
        if ({core_resp, core_rdata} !== e) begin n_err++; $display("FAIL burst_rd[%0d]: got %h/%h want %h/%h", i, core_resp, core_rdata, e[33:32], e[31:0]); end
      end
    end
  endtask
  task automatic test_errors;
    logic [31:0] a[6] = '{32'h1000, 32'h1, 32'h0, 32'h0, 32'h2, 32'h0};
    logic [1:0] w[6] = '{2, 1, 3, 0, 2, 2};
    logic cmd[6] = '{0, 1, 0, 0, 1, 0};
    logic [2:0] bl[6] = '{1, 1, 1, 2, 1, 1};
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (core_req_ack !== 1'b1) begin n_err++; $display("FAIL err_ack[%0d]: got %b want 1", i, core_req_ack); end
      start(cmd[i], w[i], a[i], bl[i], 32'hFFFF_FFFF);
      if (i == 5) push_beat(LOK, 3);
      else push_err();
      while (sb.size() != 0) begin
        @(negedge clk);
        core_req = 1'b0;
        e = sb.pop_front();
        n_vec++;
        if ({core_resp, core_rdata} !== e) begin n_err++; $display("FAIL err[%0d]: got %h/%h want %h/%h", i, core_resp, core_rdata, e[33:32], e[31:0]); end
      end
    end
  endtask
  task automatic test_reset_mid_burst;
    n_vec++;
    if (core_req_ack !== 1'b1) begin n_err++; $display("FAIL mid_ack: got %b want 1", core_req_ack); end
    start(1'b0, 2'd2, 32'h3F8, 3'd4, 0);
    push_beat(OK, 1); push_beat(OK, 2);
    while (sb.size() != 0) begin
      @(negedge clk);
      core_req = 1'b0;
      e = sb.pop_front();
      n_vec++;
      if ({core_resp, core_rdata} !== e) begin n_err++; $display("FAIL mid_rd: got %h/%h want %h/%h", core_resp, core_rdata, e[33:32], e[31:0]); end
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec += 2;
    if (core_resp !== NR) begin n_err++; $display("FAIL mid_rst_resp: got %h want %h", core_resp, NR); end
    if (core_rdata !== 32'd0) begin n_err++; $display("FAIL mid_rst_rdata: got %h want 0", core_rdata); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_vec += 2;
      if (core_resp !== NR) begin n_err++; $display("FAIL mid_post_resp: got %h want %h", core_resp, NR); end
      if (core_req_ack !== 1'b1) begin n_err++; $display("FAIL mid_post_ack: got %b want 1", core_req_ack); end
    end
    start(1'b0, 2'd2, 32'h3FC, 3'd1, 0);
    push_beat(LOK, 2);
    while (sb.size() != 0) begin
      @(negedge clk);
      core_req = 1'b0;
      e = sb.pop_front();
      n_vec++;
      if ({core_resp, core_rdata} !== e) begin n_err++; $display("FAIL mid_reread: got %h/%h want %h/%h", core_resp, core_rdata, e[33:32], e[31:0]); end
    end
  endtask
  task automatic test_random;
    logic [31:0] mdl[8];
    logic [31:0] d;
    logic [1:0] w, l;
    int j;
    for (int i = 0; i < 24; i++) begin
      j = i < 16 ? i % 8 : i - 16;
      d = $urandom;
      w = i < 8 ? 2'd2 : 2'($urandom_range(0, 2));
      l = w == 2'd0 ? 2'($urandom_range(0, 3)) : w == 2'd1 ? {1'($urandom_range(0, 1)), 1'b0} : 2'd0;
      if (i < 16) begin
        if (w == 2'd2) mdl[j] = d;
        else if (w == 2'd1) mdl[j][8*l +: 16] = d[8*l +: 16];
        else mdl[j][8*l +: 8] = d[8*l +: 8];
      end
      n_vec++;
      if (core_req_ack !== 1'b1) begin n_err++; $display("FAIL rnd_ack[%0d]: got %b want 1", i, core_req_ack); end
      start(i < 16, i < 16 ? w : 2'd2, 32'h80 + 32'(j * 4) + (i < 16 ? 32'(l) : 32'd0), 3'd1, d);
      push_beat(LOK, i < 16 ? 32'd0 : mdl[j]);
      while (sb.size() != 0) begin
        @(negedge clk);
        core_req = 1'b0;
        e = sb.pop_front();
        n_vec++;
        if ({core_resp, core_rdata} !== e) begin n_err++; $display("FAIL rnd[%0d]: got %h/%h want %h/%h", i, core_resp, core_rdata, e[33:32], e[31:0]); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_rw();
    test_burst();
    test_errors();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
